// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: bus responder with per-bit direction, a two-flop input
// synchronizer and a level interrupt raised by enabled rising edges on input pins.
module gpio_port #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   DIR_RESET = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       busAddress,
    input  logic [WIDTH-1:0] busDataIn,
    output logic [WIDTH-1:0] busDataOut,
    input  logic             busValid,
    input  logic             busWriteEnable,
    output logic             busReady,
    input  logic [WIDTH-1:0] pinIn,
    output logic [WIDTH-1:0] pinOut,
    output logic [WIDTH-1:0] pinOE,
    output logic             irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data_out, r_dir, r_irq_en, r_irq_st;
    logic [WIDTH-1:0] r_sync1, r_sync2, r_prev, r_rdata;
    logic [WIDTH-1:0] w_rdata, w_rise, w_w1c;
    logic             w_access, w_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            IDLE: if (busValid) begin
                w_access    = 1'b1;
                w_state_nxt = ACK;
            end
            ACK:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_wr = w_access & busWriteEnable;

    // Read data reflects register contents before a write sampled on the same edge.
    always_comb begin
        w_rdata = '0;
        case (busAddress)
            3'd0: w_rdata = r_data_out;
            3'd1: w_rdata = r_dir;
            3'd2: w_rdata = r_sync2;
            3'd6: w_rdata = r_irq_en;
            3'd7: w_rdata = r_irq_st;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out <= '0;
            r_dir      <= DIR_RESET;
            r_irq_en   <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_access) r_rdata <= w_rdata;
            if (w_wr) begin
                case (busAddress)
                    3'd0: r_data_out <= busDataIn;
                    3'd1: r_dir      <= busDataIn;
                    3'd3: r_data_out <= r_data_out | busDataIn;
                    3'd4: r_data_out <= r_data_out & ~busDataIn;
                    3'd5: r_data_out <= r_data_out ^ busDataIn;
                    3'd6: r_irq_en   <= busDataIn;
                    default: ;
                endcase
            end
        end
    end

    // Only enabled input-mode pins interrupt; a new edge beats a same-cycle W1C.
    assign w_rise = r_sync2 & ~r_prev & r_dir & r_irq_en;
    assign w_w1c  = (w_wr && busAddress == 3'd7) ? busDataIn : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_irq_st <= '0;
        end else begin
            r_sync1  <= pinIn;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_irq_st <= (r_irq_st & ~w_w1c) | w_rise;
        end
    end

    assign busReady   = (r_state == ACK);
    assign busDataOut = busReady ? r_rdata : '0;
    assign pinOut     = r_data_out;
    assign pinOE      = ~r_dir;
    assign irq        = |r_irq_st;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register access, set/clear/toggle, input sync,
// interrupt edge detection, W1C collision and reset during an acknowledge.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  busAddress;
    logic [31:0] busDataIn, busDataOut, pinIn, pinOut, pinOE;
    logic        busValid, busWriteEnable, busReady, irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd;

    gpio_port dut (
        .clk(clk), .reset(reset), .busAddress(busAddress), .busDataIn(busDataIn),
        .busDataOut(busDataOut), .busValid(busValid), .busWriteEnable(busWriteEnable),
        .busReady(busReady), .pinIn(pinIn), .pinOut(pinOut), .pinOE(pinOE), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access; checks the single-cycle acknowledge and returns read data.
    task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] r);
        @(negedge clk);
        busValid = 1'b1; busWriteEnable = we; busAddress = a; busDataIn = d;
        @(posedge clk); #1;
        chk("ready", {31'b0, busReady}, 32'h1);
        r = busDataOut;
        @(negedge clk);
        busValid = 1'b0; busWriteEnable = 1'b0;
        @(posedge clk); #1;
        chk("ready_drop", {31'b0, busReady}, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; busAddress = '0; busDataIn = '0; busValid = 1'b0;
        busWriteEnable = 1'b0; pinIn = '0;
        cycles(2);
        chk("rst_ready", {31'b0, busReady}, 32'h0);
        chk("rst_pinOE", pinOE, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk); reset = 1'b1;

        // Reset values
        rd_chk("dir_rst", 3'd1, 32'hFFFF_FFFF);
        rd_chk("dout_rst", 3'd0, 32'h0);
        rd_chk("irqen_rst", 3'd6, 32'h0);
        chk("dataout_idle", busDataOut, 32'h0);

        // Output path and atomic bit ops
        wr(3'd1, 32'hFFFF_FFFE);
        wr(3'd0, 32'h1);
        chk("pinOE", pinOE, 32'h1);
        chk("pinOut0", {31'b0, pinOut[0]}, 32'h1);
        wr(3'd3, 32'h6);
        chk("set", pinOut, 32'h7);
        wr(3'd4, 32'h1);
        chk("clear", pinOut, 32'h6);
        wr(3'd5, 32'h3);
        rd_chk("toggle", 3'd0, 32'h5);
        rd_chk("set_reads0", 3'd3, 32'h0);
        rd_chk("tgl_reads0", 3'd5, 32'h0);

        // Input synchronizer: capture on first edge after change sees old value
        @(negedge clk);
        pinIn[3] = 1'b1;
        busValid = 1'b1; busWriteEnable = 1'b0; busAddress = 3'd2;
        @(posedge clk); #1;
        chk("din_early", busDataOut & 32'h8, 32'h0);
        @(negedge clk); busValid = 1'b0;
        cycles(2);
        rd_chk("din_late", 3'd2, 32'h8);
        @(negedge clk); pinIn[3] = 1'b0;
        cycles(4);

        // Interrupt on the 3rd edge after the rising pin
        wr(3'd6, 32'h8);
        @(negedge clk); pinIn[3] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("irq_e2", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("irq_e3", {31'b0, irq}, 32'h1);
        rd_chk("irq_st", 3'd7, 32'h8);
        wr(3'd7, 32'h8);
        rd_chk("irq_clr", 3'd7, 32'h0);
        chk("irq_clr_line", {31'b0, irq}, 32'h0);

        // Enabling with pin already high does not set status
        wr(3'd6, 32'h0);
        wr(3'd6, 32'h8);
        cycles(4);
        chk("en_high", {31'b0, irq}, 32'h0);

        // Output-mode pin never interrupts
        @(negedge clk); pinIn[3] = 1'b0;
        wr(3'd1, 32'hFFFF_FFF6);
        cycles(3);
        @(negedge clk); pinIn[3] = 1'b1;
        cycles(6);
        chk("out_noirq", {31'b0, irq}, 32'h0);
        @(negedge clk); pinIn[3] = 1'b0;
        wr(3'd1, 32'hFFFF_FFFE);
        cycles(4);

        // W1C sampled on the same edge the rise fires: set wins
        @(negedge clk); pinIn[3] = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        busValid = 1'b1; busWriteEnable = 1'b1; busAddress = 3'd7; busDataIn = 32'h8;
        @(posedge clk); #1;
        chk("coll_ready", {31'b0, busReady}, 32'h1);
        chk("coll_irq", {31'b0, irq}, 32'h1);
        @(negedge clk); busValid = 1'b0; busWriteEnable = 1'b0;
        rd_chk("coll_st", 3'd7, 32'h8);

        // IRQ_EN=0 leaves status set
        wr(3'd6, 32'h0);
        rd_chk("en0_keep", 3'd7, 32'h8);

        // Reset while in ACK
        @(negedge clk);
        busValid = 1'b1; busWriteEnable = 1'b1; busAddress = 3'd0; busDataIn = 32'hA5;
        @(posedge clk); #1;
        chk("mid_ack", {31'b0, busReady}, 32'h1);
        reset = 1'b0; #1;
        chk("mid_rdy", {31'b0, busReady}, 32'h0);
        chk("mid_pinOut", pinOut, 32'h0);
        chk("mid_pinOE", pinOE, 32'h0);
        chk("mid_irq", {31'b0, irq}, 32'h0);
        @(negedge clk); busValid = 1'b0; busWriteEnable = 1'b0;
        @(negedge clk); reset = 1'b1;
        rd_chk("post_dir", 3'd1, 32'hFFFF_FFFF);
        rd_chk("post_dout", 3'd0, 32'h0);
        rd_chk("post_st", 3'd7, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
